// File: rtl/exe_stage_mc.sv
// Registered ARM execute stage: Val2 generation, ALU, flags, branch target, EXE/MEM register.
// Define EXE_MUL_EN to include the iterative multiplier and its IDLE/MUL/DONE FSM.
module exe_stage_mc #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_BPC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              out_stall,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              S,
  input  logic              B,
  input  logic              MEM_W_EN,
  input  logic              MEM_R_EN,
  input  logic              WB_EN,
  input  logic              imm,
  input  logic [3:0]        EXE_CMD,
  input  logic [DATA_W-1:0] Val1,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [11:0]       Shift_operand,
  input  logic [23:0]       Signed_imm_24,
  input  logic [3:0]        Dest,
  input  logic              C,
  input  logic              V,
  input  logic              Z,
  input  logic              N,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALU_Res,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic [DATA_W-1:0] Branch_Address,
  output logic [3:0]        Dest_out,
  output logic              MEM_W_EN_out,
  output logic              MEM_R_EN_out,
  output logic              WB_EN_out,
  output logic              S_out,
  output logic              B_out,
  output logic              C_out,
  output logic              V_out,
  output logic              Z_out,
  output logic              N_out
);

  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;
  localparam logic [3:0] CmdMul = 4'b1010;

  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [DATA_W-1:0] br_addr;
    logic [3:0]        dest;
    logic              mem_w;
    logic              mem_r;
    logic              wb;
    logic              s;
    logic              b;
    logic              c;
    logic              v;
    logic              z;
    logic              n;
  } out_t;

  logic [DATA_W-1:0] val2;
  logic [31:0]       imm8;
  logic [4:0]        imm_rot;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] addb;
  logic [DATA_W:0]   sum;
  logic              cin, arith, c_n, v_n, is_mul;
  out_t              nxt, out_q, out_d, mul_bundle;
  logic              ov_q, ov_d;
  logic              accept, start_mul, mul_load, fsm_idle;

  always_comb begin
    val2    = '0;
    imm8    = {24'b0, Shift_operand[7:0]};
    imm_rot = {Shift_operand[11:8], 1'b0};
    if (MEM_R_EN || MEM_W_EN) begin
      val2 = DATA_W'(Shift_operand);
    end else if (imm) begin
      val2 = DATA_W'(32'({imm8, imm8} >> imm_rot));
    end else begin
      unique case (Shift_operand[6:5])
        2'b00:   val2 = Val_Rm << Shift_operand[11:7];
        2'b01:   val2 = Val_Rm >> Shift_operand[11:7];
        2'b10:   val2 = $signed(Val_Rm) >>> Shift_operand[11:7];
        default: val2 = DATA_W'({Val_Rm, Val_Rm} >> Shift_operand[11:7]);
      endcase
    end
  end

  // Subtracts are done as Val1 + ~Val2 + carry-in so C comes out as NOT borrow.
  always_comb begin
    res   = '0;
    c_n   = C;
    v_n   = V;
    arith = 1'b0;
    addb  = val2;
    cin   = 1'b0;
    unique case (EXE_CMD)
      CmdMov: res = val2;
      CmdMvn: res = ~val2;
      CmdAdd: arith = 1'b1;
      CmdAdc: begin arith = 1'b1; cin = C; end
      CmdSub: begin arith = 1'b1; addb = ~val2; cin = 1'b1; end
      CmdSbc: begin arith = 1'b1; addb = ~val2; cin = C; end
      CmdAnd: res = Val1 & val2;
      CmdOrr: res = Val1 | val2;
      CmdEor: res = Val1 ^ val2;
      default: res = '0;
    endcase
    sum = {1'b0, Val1} + {1'b0, addb} + {{DATA_W{1'b0}}, cin};
    if (arith) begin
      res = sum[DATA_W-1:0];
      c_n = sum[DATA_W];
      v_n = (Val1[DATA_W-1] == addb[DATA_W-1]) && (res[DATA_W-1] != Val1[DATA_W-1]);
    end
  end

  assign is_mul = (EXE_CMD == CmdMul);

  always_comb begin
    nxt         = '0;
    nxt.alu_res = res;
    nxt.val_rm  = Val_Rm;
    nxt.br_addr = pc_in + {{(DATA_W-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    nxt.dest    = Dest;
    nxt.mem_w   = MEM_W_EN;
    nxt.mem_r   = MEM_R_EN;
    nxt.wb      = WB_EN && !is_mul;
    nxt.s       = S;
    nxt.b       = B;
    nxt.c       = C;
    nxt.v       = V;
    nxt.z       = Z;
    nxt.n       = N;
    if (is_mul) begin
      nxt.alu_res = '0;
`ifdef EXE_MUL_EN
      nxt.wb      = WB_EN;
`endif
    end else if (S) begin
      nxt.c = c_n;
      nxt.v = v_n;
      nxt.z = (res == '0);
      nxt.n = res[DATA_W-1];
    end
  end

  assign in_ready = rst && fsm_idle && (!ov_q || !out_stall);
  assign accept   = in_valid && in_ready && !flush;

`ifdef EXE_MUL_EN
  localparam int unsigned Steps = DATA_W / MUL_BPC;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mpr_q, mpr_d, partial;
  out_t              hold_q, hold_d;

  assign fsm_idle  = (state_q == StIdle);
  assign start_mul = is_mul;

  always_comb begin
    partial = '0;
    for (int unsigned j = 0; j < MUL_BPC; j++) begin
      if (mpr_q[j]) partial = partial + (mcand_q << j);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mpr_d    = mpr_q;
    hold_d   = hold_q;
    mul_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && start_mul) begin
          state_d = StMul;
          cnt_d   = CntW'(Steps);
          acc_d   = '0;
          mcand_d = Val1;
          mpr_d   = Val_Rm;
          hold_d  = nxt;
        end
      end
      StMul: begin
        acc_d   = acc_q + partial;
        mcand_d = mcand_q << MUL_BPC;
        mpr_d   = mpr_q >> MUL_BPC;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        if (!ov_q || !out_stall) begin
          mul_load = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      mul_load = 1'b0;
    end
  end

  always_comb begin
    mul_bundle         = hold_q;
    mul_bundle.alu_res = acc_q;
    if (hold_q.s) begin
      mul_bundle.n = acc_q[DATA_W-1];
      mul_bundle.z = (acc_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mpr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mpr_q   <= mpr_d;
      hold_q  <= hold_d;
    end
  end
`else
  assign fsm_idle   = 1'b1;
  assign start_mul  = 1'b0;
  assign mul_load   = 1'b0;
  assign mul_bundle = '0;
`endif

  always_comb begin
    out_d = out_q;
    ov_d  = ov_q;
    if (flush) begin
      ov_d = 1'b0;
    end else if (accept && !start_mul) begin
      out_d = nxt;
      ov_d  = 1'b1;
    end else if (mul_load) begin
      out_d = mul_bundle;
      ov_d  = 1'b1;
    end else if (!(ov_q && out_stall)) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      ov_q  <= ov_d;
    end
  end

  assign out_valid      = ov_q;
  assign ALU_Res        = out_q.alu_res;
  assign Val_Rm_out     = out_q.val_rm;
  assign Branch_Address = out_q.br_addr;
  assign Dest_out       = out_q.dest;
  assign MEM_W_EN_out   = out_q.mem_w;
  assign MEM_R_EN_out   = out_q.mem_r;
  assign WB_EN_out      = out_q.wb;
  assign S_out          = out_q.s;
  assign B_out          = out_q.b;
  assign C_out          = out_q.c;
  assign V_out          = out_q.v;
  assign Z_out          = out_q.z;
  assign N_out          = out_q.n;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed self-checking bench for exe_stage_mc (DATA_W=32, MUL_BPC=2).
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_stall;
  logic [31:0] pc_in, Val1, Val_Rm;
  logic        S, B, MEM_W_EN, MEM_R_EN, WB_EN, imm;
  logic [3:0]  EXE_CMD, Dest;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic        C, V, Z, N;
  logic        out_valid;
  logic [31:0] ALU_Res, Val_Rm_out, Branch_Address;
  logic [3:0]  Dest_out;
  logic        MEM_W_EN_out, MEM_R_EN_out, WB_EN_out, S_out, B_out;
  logic        C_out, V_out, Z_out, N_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_stage_mc #(.DATA_W(32), .MUL_BPC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_stall(out_stall), .pc_in(pc_in), .S(S), .B(B), .MEM_W_EN(MEM_W_EN),
    .MEM_R_EN(MEM_R_EN), .WB_EN(WB_EN), .imm(imm), .EXE_CMD(EXE_CMD), .Val1(Val1),
    .Val_Rm(Val_Rm), .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
    .Dest(Dest), .C(C), .V(V), .Z(Z), .N(N), .out_valid(out_valid), .ALU_Res(ALU_Res),
    .Val_Rm_out(Val_Rm_out), .Branch_Address(Branch_Address), .Dest_out(Dest_out),
    .MEM_W_EN_out(MEM_W_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .WB_EN_out(WB_EN_out),
    .S_out(S_out), .B_out(B_out), .C_out(C_out), .V_out(V_out), .Z_out(Z_out),
    .N_out(N_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic [3:0] exp_nzcv);
    check(tag, {28'b0, N_out, Z_out, C_out, V_out}, {28'b0, exp_nzcv});
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; flush = 0; out_stall = 0; pc_in = 0; Val1 = 0; Val_Rm = 0;
    S = 0; B = 0; MEM_W_EN = 0; MEM_R_EN = 0; WB_EN = 0; imm = 0; EXE_CMD = 0; Dest = 0;
    Shift_operand = 0; Signed_imm_24 = 0; C = 0; V = 0; Z = 0; N = 0;
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_res", ALU_Res, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ADD immediate with signed overflow
    in_valid = 1; EXE_CMD = 4'b0010; S = 1; Val1 = 32'h7FFF_FFFF; imm = 1;
    Shift_operand = 12'h001; Dest = 4'hA; WB_EN = 1;
    tick();
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_res", ALU_Res, 32'h8000_0000);
    flags("add_nzcv", 4'b1001);
    check("add_dest", {28'b0, Dest_out}, 32'hA);

    // SUB equal registers
    EXE_CMD = 4'b0100; Val1 = 5; Val_Rm = 5; imm = 0; Shift_operand = 12'h000;
    tick();
    check("sub_res", ALU_Res, 32'd0);
    flags("sub_nzcv", 4'b0110);
    check("sub_valrm", Val_Rm_out, 32'd5);

    // MOV rotated immediate, S=0 flags pass through, branch target
    EXE_CMD = 4'b0001; S = 0; imm = 1; Shift_operand = 12'h4FF; C = 1; N = 1;
    B = 1; pc_in = 32'h100; Signed_imm_24 = 24'hFFFFFE;
    tick();
    check("mov_imm_res", ALU_Res, 32'hFF00_0000);
    flags("mov_s0_nzcv", 4'b1010);
    check("branch_addr", Branch_Address, 32'h0000_00F8);
    check("branch_b", {31'b0, B_out}, 32'd1);
    B = 0; C = 0; N = 0;

    // Register shifts
    imm = 0; Val_Rm = 32'h8000_0010;
    Shift_operand = 12'h240; tick();
    check("asr4", ALU_Res, 32'hF800_0001);
    Shift_operand = 12'h260; tick();
    check("ror4", ALU_Res, 32'h0800_0001);
    Shift_operand = 12'h200; tick();
    check("lsl4", ALU_Res, 32'h0000_0100);
    Shift_operand = 12'h220; tick();
    check("lsr4", ALU_Res, 32'h0800_0001);

    // Memory offset
    EXE_CMD = 4'b0010; MEM_R_EN = 1; Val1 = 32'h1000; Shift_operand = 12'hFFF;
    tick();
    check("mem_off", ALU_Res, 32'h0000_1FFF);
    check("mem_r_out", {31'b0, MEM_R_EN_out}, 32'd1);
    MEM_R_EN = 0;

    // ADC and SBC
    EXE_CMD = 4'b0011; S = 1; imm = 1; Shift_operand = 12'h000; Val1 = 32'hFFFF_FFFF; C = 1;
    tick();
    check("adc_res", ALU_Res, 32'd0);
    flags("adc_nzcv", 4'b0110);
    EXE_CMD = 4'b0101; Val1 = 32'd0; C = 0;
    tick();
    check("sbc_res", ALU_Res, 32'hFFFF_FFFF);
    flags("sbc_nzcv", 4'b1000);

    // Stall holds output
    EXE_CMD = 4'b1000; S = 0; Val1 = 32'hF0F0; Shift_operand = 12'h0FF;
    tick();
    check("eor_res", ALU_Res, 32'h0000_F00F);
    out_stall = 1; EXE_CMD = 4'b0110; Val1 = 32'hFF; Shift_operand = 12'h00F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_res", ALU_Res, 32'h0000_F00F);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_stall = 0;
    tick();
    check("post_stall_and", ALU_Res, 32'h0000_000F);
    in_valid = 0;
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // Flush beats accept, and clears a held output
    in_valid = 1; flush = 1;
    tick();
    check("flush_accept", {31'b0, out_valid}, 32'd0);
    flush = 0;
    tick();
    check("load_before_flush", {31'b0, out_valid}, 32'd1);
    in_valid = 0; out_stall = 1; flush = 1;
    tick();
    check("flush_held", {31'b0, out_valid}, 32'd0);
    flush = 0; out_stall = 0;

`ifdef EXE_MUL_EN
    EXE_CMD = 4'b1010; S = 1; WB_EN = 1; imm = 0; Shift_operand = 12'h000;
    Val1 = 32'h0000_FFFF; Val_Rm = 32'h0001_0001; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("mul_busy_ready", {31'b0, in_ready}, 32'd0);
      check("mul_busy_valid", {31'b0, out_valid}, 32'd0);
    end
    tick();
    check("mul_valid", {31'b0, out_valid}, 32'd1);
    check("mul_res", ALU_Res, 32'hFFFF_FFFF);
    check("mul_n", {31'b0, N_out}, 32'd1);
    check("mul_wb", {31'b0, WB_EN_out}, 32'd1);

    in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    flush = 1;
    tick();
    flush = 0;
    check("mul_flush_valid", {31'b0, out_valid}, 32'd0);
    check("mul_flush_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) tick();
    check("mul_flush_no_result", {31'b0, out_valid}, 32'd0);

    in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    rst = 0;
    #1;
    rst = 1;
    for (int i = 0; i < 20; i++) tick();
    check("mul_rst_no_result", {31'b0, out_valid}, 32'd0);
`else
    EXE_CMD = 4'b1010; S = 1; WB_EN = 1; imm = 0; Shift_operand = 12'h000;
    Val1 = 32'h0000_FFFF; Val_Rm = 32'h0001_0001; C = 1; V = 1; Z = 0; N = 0; in_valid = 1;
    tick();
    in_valid = 0;
    check("mul_off_valid", {31'b0, out_valid}, 32'd1);
    check("mul_off_res", ALU_Res, 32'd0);
    check("mul_off_wb", {31'b0, WB_EN_out}, 32'd0);
    flags("mul_off_nzcv", 4'b0011);
    C = 0; V = 0;
`endif

    // Asynchronous reset with a valid output
    EXE_CMD = 4'b0001; imm = 1; Shift_operand = 12'h055; in_valid = 1;
    tick();
    in_valid = 0;
    check("pre_rst_res", ALU_Res, 32'h0000_0055);
    #2;
    rst = 0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_res", ALU_Res, 32'd0);
    check("async_rst_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1;
    tick();
    check("rst_release_ready", {31'b0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised, registered execute stage for the ARM pipeline. It generates Val2 (rotated immediate, shifted register or memory offset), computes ALU results, flags and the branch target, and adds an iterative multi-cycle multiplier. The EXE/MEM pipeline register is folded in behind a valid/ready handshake with stall and flush. It sits between the ID/EXE register and the memory stage.

Parameters:
DATA_W, 32, datapath/address width; must be >= 32 and even.
MUL_BPC, 2, multiplier bits retired per cycle; must divide DATA_W; multiply latency = DATA_W/MUL_BPC cycles.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept an instruction this cycle.
flush  in  1  kill the in-flight multiply and the output register contents.
out_stall  in  1  downstream cannot take the output register.
pc_in  in  DATA_W  PC+4 of the instruction.
S, B, MEM_W_EN, MEM_R_EN, WB_EN, imm  in  1 each  decoded controls.
EXE_CMD  in  4  0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL.
Val1, Val_Rm  in  DATA_W  Rn and Rm values.
Shift_operand  in  12  instruction bits [11:0].
Signed_imm_24  in  24  branch offset.
Dest  in  4  destination register.
C, V, Z, N  in  1 each  current status flags.
out_valid  out  1  output register holds a valid instruction.
ALU_Res, Val_Rm_out, Branch_Address  out  DATA_W  registered results.
Dest_out  out  4; MEM_W_EN_out, MEM_R_EN_out, WB_EN_out, S_out, B_out  out  1 each; C_out, V_out, Z_out, N_out  out  1 each.  All registered.

Behaviour:
- Reset (rst=0, async): out_valid=0, in_ready=0 while asserted, FSM=IDLE, all registered outputs 0.
- in_ready = (state==IDLE) && (!out_valid || !out_stall). Accept = in_valid && in_ready && !flush.
- Val2:
  - MEM_R_EN|MEM_W_EN: zero-extended Shift_operand[11:0].
  - imm: zero-extended Shift_operand[7:0] rotated right by 2*Shift_operand[11:8] within the low 32 bits.
  - Otherwise Val_Rm shifted by Shift_operand[11:7]: [6:5] 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Val_Rm unchanged.
- ALU, all ops mod 2^DATA_W:
  - ADC = Val1+Val2+C. SUB: C = NOT borrow. SBC = Val1-Val2-(~C).
  - V is set on signed overflow for ADD/ADC/SUB/SBC.
  - Logic ops and MOV/MVN keep C and V from the inputs. N = result MSB, Z = (result==0).
- Branch_Address = pc_in + sign_extend({Signed_imm_24,2'b00}) truncated to DATA_W.
- Single-cycle ops: on accept, the output register loads on the same edge. Latency 1 cycle.
- Flags: when S=0, C_out..N_out register the unchanged input flags.
- MUL FSM IDLE->MUL->DONE:
  - IDLE -> MUL on accept of EXE_CMD 1010. Operands and controls are captured; the counter loads DATA_W/MUL_BPC.
  - MUL: each cycle adds MUL_BPC partial products. The product is the low DATA_W bits of Val1*Val_Rm. in_ready=0. Counter reaches 0 -> DONE.
  - DONE: if !out_valid || !out_stall, load the output register (N, Z from product; C, V unchanged) -> IDLE. Otherwise hold in DONE.
  - Total latency from accept to out_valid = DATA_W/MUL_BPC + 1 cycles.
- Output register:
  - Holds all values while out_valid && out_stall.
  - Clears out_valid when drained with no new load.
- flush: clears out_valid on the next edge and forces FSM to IDLE, discarding any multiply in progress. Flush has priority over accept and over DONE loading.
- Reset mid-multiply aborts the multiply; no partial result reaches the outputs.

Optional Feature:
EXE_MUL_EN
- Defined: multiplier and FSM are present as described.
- Undefined: no FSM, and in_ready = !out_valid || !out_stall. EXE_CMD 1010 completes in 1 cycle with ALU_Res=0, WB_EN_out forced 0, and flags passed through unchanged.

Test Plan:
- Reset: rst=0 mid-run -> out_valid=0, ALU_Res=0, in_ready=0. After release, in_ready=1 within 1 cycle.
- ADD S=1, Val1=0x7FFFFFFF, imm=1, Shift_operand=0x001 -> next cycle ALU_Res=0x80000000, N=1, V=1, Z=0, C=0.
- SUB S=1, Val1=5, Val_Rm=5, register shift 0 -> ALU_Res=0, Z=1, C=1. MOV imm Shift_operand=0x4FF -> ALU_Res=0xFF000000.
- MUL, DATA_W=32, MUL_BPC=2, Val1=0xFFFF, Val_Rm=0x10001 -> in_ready low for 16 cycles; out_valid on cycle 17 with ALU_Res=0xFFFFFFFF, N=1.
- Stall: out_stall=1 with out_valid=1 for 3 cycles -> outputs stable and in_ready=0. Release -> the next instruction loads on the following edge.
- Flush during cycle 5 of a MUL -> out_valid stays 0, in_ready=1 next cycle. B=1, pc_in=0x100, Signed_imm_24=0xFFFFFE -> Branch_Address=0xF8.
